// File: rtl/cpu_host_ctrl.sv
// cpu_host_ctrl: byte-serial host command FSM driving imem writes, core reset/run bursts and debug readback.
// Optional CPU_HOST_STEP_COUNT_EN adds a retired-step counter readable with opcode 0x06.
module cpu_host_ctrl #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   input  logic [7:0]        cmd_byte,
   output logic              cmd_ready,
   output logic              rsp_valid,
   output logic [7:0]        rsp_byte,
   input  logic              rsp_ready,
   output logic              imem_wr_en,
   output logic [ADDR_W-1:0] imem_wr_addr,
   output logic [31:0]       imem_wr_data,
   output logic              cpu_rst_n,
   output logic              cpu_clk_en,
   input  logic [31:0]       debug_rd_value,
   output logic              cmd_err
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN_ARG, RUNNING, READ_OUT} state_t;
   state_t state, state_d;
   logic [1:0] cnt, cnt_d;
   logic [8:0] steps, steps_d;
   logic [23:0] asm_q, asm_d;
   logic [31:0] word, word_d, data_d;
   logic [ADDR_W-1:0] ptr, ptr_d, addr_d;
   logic [7:0] rb_d;
   logic wr_d, crst_d, clk_en_d, rv_d, err_d, rdy_d;
   logic acc, hs;
`ifdef CPU_HOST_STEP_COUNT_EN
   logic [31:0] step_cnt, step_cnt_d;
`endif
   assign acc = cmd_valid && cmd_ready;
   assign hs = rsp_valid && rsp_ready;
   always_comb begin
      state_d = state;
      cnt_d = cnt;
      steps_d = steps;
      asm_d = asm_q;
      word_d = word;
      ptr_d = ptr;
      addr_d = imem_wr_addr;
      data_d = imem_wr_data;
      rb_d = rsp_byte;
      wr_d = 1'b0;
      crst_d = cpu_rst_n;
      clk_en_d = 1'b0;
      rv_d = rsp_valid;
      err_d = 1'b0;
`ifdef CPU_HOST_STEP_COUNT_EN
      step_cnt_d = step_cnt + {31'd0, cpu_clk_en && cpu_rst_n};
`endif
      case (state)
         IDLE: if (acc) begin
            case (cmd_byte)
               8'h01: begin
                  state_d = LOAD;
                  cnt_d = 2'd0;
               end
               8'h02: begin
                  crst_d = 1'b0;
                  ptr_d = '0;
`ifdef CPU_HOST_STEP_COUNT_EN
                  step_cnt_d = '0;
`endif
               end
               8'h03: state_d = RUN_ARG;
               8'h04: begin
                  state_d = READ_OUT;
                  cnt_d = 2'd0;
                  word_d = debug_rd_value;
                  rb_d = debug_rd_value[7:0];
                  rv_d = 1'b1;
               end
               8'h05: crst_d = 1'b1;
`ifdef CPU_HOST_STEP_COUNT_EN
               8'h06: begin
                  state_d = READ_OUT;
                  cnt_d = 2'd0;
                  word_d = step_cnt;
                  rb_d = step_cnt[7:0];
                  rv_d = 1'b1;
               end
`endif
               default: err_d = 1'b1;
            endcase
         end
         // the output word only changes once all 4 bytes are in, so a partial load is never visible
         LOAD: if (acc) begin
            asm_d = {cmd_byte, asm_q[23:8]};
            cnt_d = cnt + 2'd1;
            if (cnt == 2'd3) begin
               data_d = {cmd_byte, asm_q};
               wr_d = 1'b1;
               addr_d = ptr;
               ptr_d = ptr + 1'b1;
               state_d = IDLE;
            end
         end
         RUN_ARG: if (acc) begin
            steps_d = (cmd_byte == 8'd0) ? 9'd256 : {1'b0, cmd_byte};
            clk_en_d = 1'b1;
            state_d = RUNNING;
         end
         RUNNING: begin
            steps_d = steps - 9'd1;
            clk_en_d = steps != 9'd1;
            state_d = (steps == 9'd1) ? IDLE : RUNNING;
         end
         READ_OUT: if (hs) begin
            word_d = {8'd0, word[31:8]};
            rb_d = word[15:8];
            cnt_d = cnt + 2'd1;
            if (cnt == 2'd3) begin
               rv_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == RUN_ARG);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         steps <= '0;
         asm_q <= '0;
         word <= '0;
         ptr <= '0;
         imem_wr_addr <= '0;
         imem_wr_data <= '0;
         imem_wr_en <= 1'b0;
         rsp_byte <= '0;
         rsp_valid <= 1'b0;
         cpu_rst_n <= 1'b0;
         cpu_clk_en <= 1'b0;
         cmd_err <= 1'b0;
         cmd_ready <= 1'b0;
`ifdef CPU_HOST_STEP_COUNT_EN
         step_cnt <= '0;
`endif
      end else begin
         state <= state_d;
         cnt <= cnt_d;
         steps <= steps_d;
         asm_q <= asm_d;
         word <= word_d;
         ptr <= ptr_d;
         imem_wr_addr <= addr_d;
         imem_wr_data <= data_d;
         imem_wr_en <= wr_d;
         rsp_byte <= rb_d;
         rsp_valid <= rv_d;
         cpu_rst_n <= crst_d;
         cpu_clk_en <= clk_en_d;
         cmd_err <= err_d;
         cmd_ready <= rdy_d;
`ifdef CPU_HOST_STEP_COUNT_EN
         step_cnt <= step_cnt_d;
`endif
      end
   end
endmodule
